// File: rtl/switch_pkg.sv
// Shared definitions for the mesh switch arbiter: port indices, FSM encoding,
// and helpers for address-field widths and one-hot port strobes.
package switch_pkg;

  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned PORT_W    = 3;

  localparam logic [PORT_W-1:0] PORT_LEFT  = 3'd0;
  localparam logic [PORT_W-1:0] PORT_RIGHT = 3'd1;
  localparam logic [PORT_W-1:0] PORT_UP    = 3'd2;
  localparam logic [PORT_W-1:0] PORT_DOWN  = 3'd3;
  localparam logic [PORT_W-1:0] PORT_PE    = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // Bits needed to address n rows/columns; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PORT_W-1:0] p);
    return NUM_PORTS'(1) << p;
  endfunction

endpackage

// File: rtl/switch_xy_arbiter_rr_pick5.sv
// Combinational round-robin picker over the five switch inputs.
// Ports: valid  - request vector
//        ptr    - highest-priority index (0..4)
//        grant  - one-hot winner
//        idx    - binary winner index
//        any    - at least one request present
module rr_pick5
  import switch_pkg::*;
(
  input  logic [NUM_PORTS-1:0] valid,
  input  logic [PORT_W-1:0]    ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PORT_W-1:0]    idx,
  output logic                 any
);

  logic [3:0] cand;

  // Walk ptr, ptr+1, ... (mod 5); the first valid input wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      cand = {1'b0, ptr} + 4'(i);
      if (cand >= 4'(NUM_PORTS)) cand = cand - 4'(NUM_PORTS);
      if (!any && valid[cand[PORT_W-1:0]]) begin
        any = 1'b1;
        idx = cand[PORT_W-1:0];
      end
    end
    grant = any ? port_onehot(idx) : '0;
  end

endmodule

// File: rtl/switch_xy_arbiter.sv
// Per-switch sequencing controller: round-robin pops one packet from the five
// input FIFOs and writes it to the output FIFO chosen by XY routing.
// Ports: clk, i_reset (sync, active high)
//        i_in_valid/i_in_data  - FWFT input FIFO heads
//        o_in_rd_en            - one-hot input pop strobe
//        i_out_ready           - output FIFO not-full
//        o_out_wr_en/o_out_data- one-hot output write strobe and shared data
//        o_grant, o_busy       - current owner and non-idle status
module switch_xy_arbiter
  import switch_pkg::*;
#(
  parameter int unsigned packet_size = 16,
  parameter int unsigned x           = 1,
  parameter int unsigned y           = 0,
  parameter int unsigned xno_switch  = 4,
  parameter int unsigned yno_switch  = 4
) (
  input  logic                             clk,
  input  logic                             i_reset,
  input  logic [NUM_PORTS-1:0]             i_in_valid,
  input  logic [NUM_PORTS*packet_size-1:0] i_in_data,
  output logic [NUM_PORTS-1:0]             o_in_rd_en,
  input  logic [NUM_PORTS-1:0]             i_out_ready,
  output logic [NUM_PORTS-1:0]             o_out_wr_en,
  output logic [packet_size-1:0]           o_out_data,
  output logic [NUM_PORTS-1:0]             o_grant,
  output logic                             o_busy
);

  localparam int unsigned XW = addr_w(xno_switch);
  localparam int unsigned YW = addr_w(yno_switch);
  localparam logic [XW-1:0] X_POS = XW'(x);
  localparam logic [YW-1:0] Y_POS = YW'(y);

  state_t                   state, state_d;
  logic [PORT_W-1:0]        rr_ptr, rr_ptr_d;
  logic [packet_size-1:0]   pkt_reg, pkt_d;
  logic [PORT_W-1:0]        grant_idx, grant_idx_d;
  logic [PORT_W-1:0]        out_port, out_port_d;
  logic [NUM_PORTS-1:0]     rd_en_d, wr_en_d, grant_d;
  logic [packet_size-1:0]   out_data_d;
  logic                     busy_d;

  logic [NUM_PORTS-1:0]     pick_grant;
  logic [PORT_W-1:0]        pick_idx;
  logic                     pick_any;
  logic [packet_size-1:0]   pick_data;
  logic [XW-1:0]            dx;
  logic [YW-1:0]            dy;
  logic [PORT_W-1:0]        route_port;

  rr_pick5 u_pick (
    .valid (i_in_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign pick_data = i_in_data[32'(pick_idx)*packet_size +: packet_size];

  // Destination sits in the packet MSBs: column field above row field.
  assign dx = pkt_reg[packet_size-1 -: XW];
  assign dy = pkt_reg[packet_size-1-XW -: YW];

  // Dimension-ordered routing: resolve X first, then Y, else local PE.
  always_comb begin
    route_port = PORT_PE;
    if (dx > X_POS)      route_port = PORT_RIGHT;
    else if (dx < X_POS) route_port = PORT_LEFT;
    else if (dy > Y_POS) route_port = PORT_DOWN;
    else if (dy < Y_POS) route_port = PORT_UP;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    pkt_d       = pkt_reg;
    grant_idx_d = grant_idx;
    out_port_d  = out_port;
    rd_en_d     = '0;
    wr_en_d     = '0;
    out_data_d  = o_out_data;
    grant_d     = o_grant;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          pkt_d       = pick_data;
          grant_idx_d = pick_idx;
          grant_d     = pick_grant;
          rd_en_d     = pick_grant;
          state_d     = ST_ROUTE;
        end
      end
      ST_ROUTE: begin
        out_port_d = route_port;
        if (i_out_ready[route_port]) begin
          wr_en_d    = port_onehot(route_port);
          out_data_d = pkt_reg;
          state_d    = ST_WRITE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_out_ready[out_port]) begin
          wr_en_d    = port_onehot(out_port);
          out_data_d = pkt_reg;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        rr_ptr_d = (grant_idx == PORT_PE) ? PORT_LEFT : grant_idx + 3'd1;
        grant_d  = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      pkt_reg     <= '0;
      grant_idx   <= '0;
      out_port    <= '0;
      o_in_rd_en  <= '0;
      o_out_wr_en <= '0;
      o_out_data  <= '0;
      o_grant     <= '0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      pkt_reg     <= pkt_d;
      grant_idx   <= grant_idx_d;
      out_port    <= out_port_d;
      o_in_rd_en  <= rd_en_d;
      o_out_wr_en <= wr_en_d;
      o_out_data  <= out_data_d;
      o_grant     <= grant_d;
      o_busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_switch_xy_arbiter.sv
// Self-checking bench for switch_xy_arbiter (x=1, y=0 in a 4x4 mesh).
// Input FIFOs are modelled in the bench; expected writes go to a scoreboard.
module tb_switch_xy_arbiter;

  logic        clk;
  logic        i_reset;
  logic [4:0]  i_in_valid;
  logic [79:0] i_in_data;
  logic [4:0]  o_in_rd_en;
  logic [4:0]  i_out_ready;
  logic [4:0]  o_out_wr_en;
  logic [15:0] o_out_data;
  logic [4:0]  o_grant;
  logic        o_busy;

  switch_xy_arbiter #(
    .packet_size (16),
    .x           (1),
    .y           (0),
    .xno_switch  (4),
    .yno_switch  (4)
  ) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_in_valid  (i_in_valid),
    .i_in_data   (i_in_data),
    .o_in_rd_en  (o_in_rd_en),
    .i_out_ready (i_out_ready),
    .o_out_wr_en (o_out_wr_en),
    .o_out_data  (o_out_data),
    .o_grant     (o_grant),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int port; logic [15:0] data; } exp_t;
  typedef struct { int src; logic [15:0] pkt; int port; } vec_t;

  exp_t        sb[$];
  int          grant_log[$];
  int          rd_cyc_log[$];
  vec_t        vecs[8];
  logic [15:0] fmem[5][16];
  int          fhead[5];
  int          fcnt[5];
  bit          pend[5];
  int          checks, errors, cyc;
  int          last_rd_cyc, last_wr_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < 5; k++) begin
      i_in_valid[k] = (fcnt[k] != 0);
      i_in_data[k*16 +: 16] = (fcnt[k] != 0) ? fmem[k][fhead[k]] : 16'h0;
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 5; k++) begin
      fhead[k] = 0;
      fcnt[k]  = 0;
      pend[k]  = 1'b0;
    end
    sb.delete();
    grant_log.delete();
    rd_cyc_log.delete();
    drive_inputs();
  endtask

  // Queue a packet on input k; when scored, the expected write is recorded.
  task automatic push(input int k, input logic [15:0] d, input int port, input bit scored);
    exp_t e;
    fmem[k][(fhead[k] + fcnt[k]) % 16] = d;
    fcnt[k]++;
    drive_inputs();
    if (scored) begin
      e.port = port;
      e.data = d;
      sb.push_back(e);
    end
  endtask

  // One clock: apply pops strobed last cycle, then observe this cycle's outputs.
  task automatic step();
    int   wp;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 5; k++) begin
      if (pend[k] && fcnt[k] > 0) begin
        fhead[k] = (fhead[k] + 1) % 16;
        fcnt[k]--;
      end
      pend[k] = 1'b0;
    end
    drive_inputs();
    if (o_in_rd_en != 5'b0) begin
      chk("rd_onehot", $countones(o_in_rd_en), 1);
      chk("rd_matches_grant", o_grant, o_in_rd_en);
      for (int k = 0; k < 5; k++) begin
        if (o_in_rd_en[k]) begin
          chk("rd_nonempty", (fcnt[k] != 0), 1);
          pend[k] = 1'b1;
          grant_log.push_back(k);
          rd_cyc_log.push_back(cyc);
        end
      end
      last_rd_cyc = cyc;
    end
    if (o_out_wr_en != 5'b0) begin
      wp = 0;
      for (int k = 0; k < 5; k++) if (o_out_wr_en[k]) wp = k;
      chk("wr_onehot", $countones(o_out_wr_en), 1);
      if (sb.size() == 0) begin
        chk("wr_unexpected", o_out_wr_en, 5'b0);
      end else begin
        e = sb.pop_front();
        chk("wr_port", wp, e.port);
        chk("wr_data", o_out_data, e.data);
      end
      last_wr_cyc = cyc;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || o_busy) && n < budget) begin
      step();
      n++;
    end
    chk("drain_within_budget", (n < budget), 1);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
    clear_model();
  endtask

  initial begin
    int t0;
    int idx;
    // dest nibble = {dx[1:0], dy[1:0]}; switch sits at x=1, y=0
    vecs[0] = '{4, 16'hC5A5, 1};  // (3,0) -> right
    vecs[1] = '{0, 16'h0123, 0};  // (0,0) -> left
    vecs[2] = '{0, 16'h6BCD, 3};  // (1,2) -> down
    vecs[3] = '{0, 16'h4EEF, 4};  // (1,0) -> PE
    vecs[4] = '{0, 16'hB777, 1};  // (2,3) -> right
    vecs[5] = '{2, 16'h4001, 4};  // (1,0) -> PE
    vecs[6] = '{1, 16'h3F00, 0};  // (0,3) -> left, X resolved before Y
    vecs[7] = '{3, 16'hFFFF, 1};  // (3,3) -> right

    checks = 0; errors = 0; cyc = 0;
    last_rd_cyc = -1; last_wr_cyc = -1;
    i_reset = 1'b1;
    i_in_valid = '0;
    i_in_data = '0;
    i_out_ready = 5'b11111;
    clear_model();
    do_reset();

    chk("reset_rd_en", o_in_rd_en, 5'b0);
    chk("reset_wr_en", o_out_wr_en, 5'b0);
    chk("reset_data", o_out_data, 16'h0);
    chk("reset_grant", o_grant, 5'b0);
    chk("reset_busy", o_busy, 1'b0);

    // Table-driven routing vectors with pop/write latency checks.
    for (int i = 0; i < 8; i++) begin
      t0 = cyc;
      push(vecs[i].src, vecs[i].pkt, vecs[i].port, 1'b1);
      drain(50);
      chk("vec_rd_latency", last_rd_cyc - t0, 1);
      chk("vec_wr_latency", last_wr_cyc - t0, 2);
      chk("vec_idle_grant", o_grant, 5'b0);
      chk("vec_data_held", o_out_data, vecs[i].pkt);
    end

    // Fairness from reset: all five inputs loaded with two packets each.
    do_reset();
    t0 = cyc;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 5; k++)
        push(k, 16'h4000 | 16'(k << 4) | 16'(r), 4, 1'b1);
    drain(200);
    chk("fair_count", grant_log.size(), 10);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
      chk("fair_grant", grant_log[i], i % 5);
      chk("fair_cycle", rd_cyc_log[i] - t0, 1 + 3 * i);
    end

    // Backpressure on the down output while another input waits.
    i_out_ready[3] = 1'b0;
    grant_log.delete();
    push(2, 16'h6123, 3, 1'b1);
    step();
    push(0, 16'h4ABC, 4, 1'b1);
    for (int i = 0; i < 10; i++) step();
    chk("bp_single_pop", grant_log.size(), 1);
    chk("bp_nothing_written", sb.size(), 2);
    chk("bp_busy", o_busy, 1'b1);
    chk("bp_grant_held", o_grant, 5'b00100);
    i_out_ready[3] = 1'b1;
    step();
    chk("bp_wr_after_ready", o_out_wr_en, 5'b01000);
    drain(50);
    chk("bp_next_grant", grant_log.size() > 1 ? grant_log[1] : -1, 0);

    // Reset during a stall discards the packet and restarts priority at input 0.
    i_out_ready[3] = 1'b0;
    push(1, 16'h6555, 3, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("rw_stalled_busy", o_busy, 1'b1);
    chk("rw_stalled_grant", o_grant, 5'b00010);
    i_reset = 1'b1;
    step();
    chk("rw_rd_en", o_in_rd_en, 5'b0);
    chk("rw_wr_en", o_out_wr_en, 5'b0);
    chk("rw_data", o_out_data, 16'h0);
    chk("rw_grant", o_grant, 5'b0);
    chk("rw_busy", o_busy, 1'b0);
    i_reset = 1'b0;
    clear_model();
    i_out_ready = 5'b11111;
    push(0, 16'h0333, 0, 1'b1);
    push(2, 16'h4222, 4, 1'b1);
    drain(50);
    chk("rw_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    chk("rw_second_grant", grant_log.size() > 1 ? grant_log[1] : -1, 2);

    // Pointer wrap: after input 4 wins, input 0 outranks input 3.
    grant_log.delete();
    push(4, 16'h4444, 4, 1'b1);
    drain(50);
    grant_log.delete();
    push(0, 16'h4010, 4, 1'b1);
    push(3, 16'hC030, 1, 1'b1);
    drain(50);
    idx = grant_log.size() > 0 ? grant_log[0] : -1;
    chk("wrap_first_grant", idx, 0);
    chk("wrap_second_grant", grant_log.size() > 1 ? grant_log[1] : -1, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
